// File: rtl/board_level_data_physical_decoder_if.sv
// Receive-FIFO pop side and output-FIFO write side of the 6b/8b line decoder.
// master = decoder, slave = surrounding FIFOs / environment.
interface board_level_data_physical_decoder_if;
    logic       empty;
    logic       rd;
    logic       valid;
    logic [7:0] encoded_data;
    logic       full;
    logic       wr;
    logic [5:0] out_data;
    logic       out_start;
    logic       out_end;
    logic       out_abort;

    modport master (
        input  empty, valid, encoded_data, full,
        output rd, wr, out_data, out_start, out_end, out_abort
    );

    modport slave (
        output empty, valid, encoded_data, full,
        input  rd, wr, out_data, out_start, out_end, out_abort
    );
endinterface

// File: rtl/board_level_data_physical_decoder.sv
// Board-level 6b/8b receive decoder: classifies line symbols, tracks framing,
// truncates over-long frames and writes payload/markers to the output FIFO.
module board_level_data_physical_decoder #(
    parameter int MAX_FRAME_LEN = 1024,
    parameter int LEN_WIDTH     = 11,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    board_level_data_physical_decoder_if.master bus,
    output logic [LEN_WIDTH-1:0] frame_len,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] error_count,
    output logic                 err_pulse
);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_FRAME_LEN);

    typedef enum logic [1:0] {IDLE, FRAME, DISCARD} state_t;
    typedef enum logic [2:0] {SYM_FILL, SYM_START, SYM_END, SYM_DATA, SYM_ILLEGAL} sym_t;

    state_t               state_reg, state_next;
    logic [LEN_WIDTH-1:0] len_reg, len_next;
    logic                 wr_reg, wr_next;
    logic [5:0]           data_reg, data_next;
    logic                 start_reg, start_next;
    logic                 end_reg, end_next;
    logic                 abort_reg, abort_next;
    logic                 err_reg, err_next;
    logic [LEN_WIDTH-1:0] frame_len_reg, frame_len_next;
    logic [CNT_WIDTH-1:0] frame_count_reg, frame_count_next;
    logic [CNT_WIDTH-1:0] error_count_reg, error_count_next;

    sym_t       sym_kind;
    logic [5:0] payload;

    for (genvar gi = 0; gi < 6; gi++) begin : g_payload
        assign payload[gi] = bus.encoded_data[gi+2];
    end

    // Pop only when the output side can absorb the word already in flight.
    assign bus.rd = ~bus.full & ~bus.empty & ~rst;

    always_comb begin
        sym_kind = SYM_ILLEGAL;
        if (bus.encoded_data == 8'h00)
            sym_kind = SYM_FILL;
        else if (bus.encoded_data == 8'h01)
            sym_kind = SYM_START;
        else if (bus.encoded_data == 8'h02)
            sym_kind = SYM_END;
        else if (bus.encoded_data[1:0] == 2'b11)
            sym_kind = SYM_DATA;
    end

    always_comb begin
        state_next       = state_reg;
        len_next         = len_reg;
        wr_next          = 1'b0;
        data_next        = 6'd0;
        start_next       = 1'b0;
        end_next         = 1'b0;
        abort_next       = 1'b0;
        err_next         = 1'b0;
        frame_len_next   = frame_len_reg;
        frame_count_next = frame_count_reg;
        error_count_next = error_count_reg;

        if (bus.valid) begin
            unique case (sym_kind)
                SYM_FILL: ;
                SYM_START: begin
                    wr_next    = 1'b1;
                    start_next = 1'b1;
                    len_next   = '0;
                    if (state_reg == FRAME) begin
                        abort_next = 1'b1;
                        err_next   = 1'b1;
                    end
                    state_next = FRAME;
                end
                SYM_END: begin
                    case (state_reg)
                        FRAME: begin
                            wr_next          = 1'b1;
                            end_next         = 1'b1;
                            frame_len_next   = len_reg;
                            frame_count_next = frame_count_reg + CNT_WIDTH'(1);
                            state_next       = IDLE;
                        end
                        DISCARD: state_next = IDLE;
                        default: err_next = 1'b1;
                    endcase
                end
                SYM_DATA: begin
                    case (state_reg)
                        FRAME: begin
                            if (len_reg < MAX_LEN) begin
                                wr_next   = 1'b1;
                                data_next = payload;
                                len_next  = len_reg + LEN_WIDTH'(1);
                            end else begin
                                // Over-long frame: close it as aborted and drop the rest.
                                wr_next    = 1'b1;
                                end_next   = 1'b1;
                                abort_next = 1'b1;
                                err_next   = 1'b1;
                                state_next = DISCARD;
                            end
                        end
                        DISCARD: ;
                        default: err_next = 1'b1;
                    endcase
                end
                default: err_next = 1'b1;
            endcase
        end

        if (err_next && (error_count_reg != {CNT_WIDTH{1'b1}}))
            error_count_next = error_count_reg + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            len_reg         <= '0;
            wr_reg          <= 1'b0;
            data_reg        <= 6'd0;
            start_reg       <= 1'b0;
            end_reg         <= 1'b0;
            abort_reg       <= 1'b0;
            err_reg         <= 1'b0;
            frame_len_reg   <= '0;
            frame_count_reg <= '0;
            error_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            len_reg         <= len_next;
            wr_reg          <= wr_next;
            data_reg        <= data_next;
            start_reg       <= start_next;
            end_reg         <= end_next;
            abort_reg       <= abort_next;
            err_reg         <= err_next;
            frame_len_reg   <= frame_len_next;
            frame_count_reg <= frame_count_next;
            error_count_reg <= error_count_next;
        end
    end

    assign bus.wr        = wr_reg;
    assign bus.out_data  = data_reg;
    assign bus.out_start = start_reg;
    assign bus.out_end   = end_reg;
    assign bus.out_abort = abort_reg;
    assign err_pulse     = err_reg;
    assign frame_len     = frame_len_reg;
    assign frame_count   = frame_count_reg;
    assign error_count   = error_count_reg;
endmodule

// File: tb/tb_board_level_data_physical_decoder.sv
// Bench for the 6b/8b receive decoder: directed vectors, corner sequences and
// random traffic compared every cycle against a behavioural frame model.
module tb_board_level_data_physical_decoder;
    localparam int MAXF = 4;
    localparam int LW   = 11;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [LW-1:0] frame_len;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] error_count;
    logic          err_pulse;

    board_level_data_physical_decoder_if bus ();

    board_level_data_physical_decoder #(
        .MAX_FRAME_LEN(MAXF), .LEN_WIDTH(LW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .frame_len(frame_len), .frame_count(frame_count),
        .error_count(error_count), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int writes   = 0;

    logic [7:0] src_q[$];

    // Reference model: frame bookkeeping from the classification rules.
    bit in_frame, discarding;
    int m_len, m_fl, m_fc, m_ec;
    logic       e_wr, e_start, e_end, e_abort, e_err;
    logic [5:0] e_data;

    function automatic void model_eval(input logic r, input logic v, input logic [7:0] s);
        bit err;
        err = 0;
        e_wr = 0; e_start = 0; e_end = 0; e_abort = 0; e_err = 0; e_data = 0;
        if (r) begin
            in_frame = 0; discarding = 0;
            m_len = 0; m_fl = 0; m_fc = 0; m_ec = 0;
            return;
        end
        if (!v || s == 8'h00) return;
        if (s == 8'h01) begin
            e_wr = 1; e_start = 1;
            if (in_frame) begin e_abort = 1; err = 1; end
            in_frame = 1; discarding = 0; m_len = 0;
        end else if (s == 8'h02) begin
            if (in_frame) begin
                e_wr = 1; e_end = 1; m_fl = m_len;
                m_fc = (m_fc + 1) % (1 << CW);
                in_frame = 0;
            end else if (discarding) discarding = 0;
            else err = 1;
        end else if (s[1:0] == 2'b11) begin
            if (in_frame) begin
                if (m_len < MAXF) begin
                    e_wr = 1; e_data = s[7:2]; m_len++;
                end else begin
                    e_wr = 1; e_end = 1; e_abort = 1; err = 1;
                    in_frame = 0; discarding = 1;
                end
            end else if (!discarding) err = 1;
        end else err = 1;
        e_err = err;
        if (err && m_ec < (1 << CW) - 1) m_ec++;
    endfunction

    task automatic push(input logic [7:0] s);
        src_q.push_back(s);
        bus.empty = 1'b0;
    endtask

    // One clock: model the current inputs, emulate a 1-cycle-latency FIFO pop,
    // then compare every output on the falling edge.
    task automatic step();
        logic rd_s, exp_rd;
        model_eval(rst, bus.valid, bus.encoded_data);
        rd_s = bus.rd;
        @(posedge clk);
        #1;
        if (rd_s && src_q.size() > 0) begin
            bus.valid = 1'b1;
            bus.encoded_data = src_q.pop_front();
        end else begin
            bus.valid = 1'b0;
            bus.encoded_data = 8'($urandom);
        end
        bus.empty = (src_q.size() == 0);
        @(negedge clk);
        exp_rd = ~bus.full & ~bus.empty & ~rst;
        checks++;
        if (bus.wr !== e_wr || bus.out_data !== e_data || bus.out_start !== e_start ||
            bus.out_end !== e_end || bus.out_abort !== e_abort || err_pulse !== e_err ||
            int'(frame_len) != m_fl || int'(frame_count) != m_fc ||
            int'(error_count) != m_ec || bus.rd !== exp_rd) begin
            failures++;
            $display("FAIL cycle_outputs t=%0t got wr=%b d=%h s=%b e=%b a=%b err=%b fl=%0d fc=%0d ec=%0d rd=%b expected wr=%b d=%h s=%b e=%b a=%b err=%b fl=%0d fc=%0d ec=%0d rd=%b",
                     $time, bus.wr, bus.out_data, bus.out_start, bus.out_end, bus.out_abort,
                     err_pulse, frame_len, frame_count, error_count, bus.rd,
                     e_wr, e_data, e_start, e_end, e_abort, e_err, m_fl, m_fc, m_ec, exp_rd);
        end
        if (bus.wr === 1'b1) writes++;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((src_q.size() > 0 || bus.valid) && budget < 200) begin
            step();
            budget++;
        end
        checks++;
        if (budget >= 200) begin
            failures++;
            $display("FAIL drain_timeout got pending=%0d required 0", src_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_status(input string name, input int fl, input int fc, input int ec, input int nw);
        checks++;
        if (int'(frame_len) != fl || int'(frame_count) != fc || int'(error_count) != ec || writes != nw) begin
            failures++;
            $display("FAIL %s got fl=%0d fc=%0d ec=%0d writes=%0d required fl=%0d fc=%0d ec=%0d writes=%0d",
                     name, frame_len, frame_count, error_count, writes, fl, fc, ec, nw);
        end
        $display("vector %s: fl=%0d fc=%0d ec=%0d writes=%0d", name, frame_len, frame_count, error_count, writes);
    endtask

    typedef struct {
        string       name;
        logic [63:0] syms;
        int          n;
        int          fl, fc, ec, nw;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"basic_frame",  64'h02FF0701,       4, 2, 1, 0, 4};
        vecs[1] = '{"fill_illegal", 64'h02010500,       4, 0, 1, 1, 2};
        vecs[2] = '{"truncate",     64'h020303030303_01, 7, 0, 0, 1, 6};
        vecs[3] = '{"restart",      64'h0213010B01,     5, 1, 1, 1, 5};
        vecs[4] = '{"orphans",      64'h020F,           2, 0, 0, 2, 0};
        vecs[5] = '{"exact_max",    64'h020F0B070301,   6, 4, 1, 0, 6};

        rst = 1'b1;
        bus.empty = 1'b1;
        bus.full = 1'b0;
        bus.valid = 1'b0;
        bus.encoded_data = 8'h00;
        model_eval(1'b1, 1'b0, 8'h00);

        do_reset();
        check_status("reset", 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            writes = 0;
            for (int k = 0; k < vecs[i].n; k++) push(vecs[i].syms[k*8 +: 8]);
            drain();
            check_status(vecs[i].name, vecs[i].fl, vecs[i].fc, vecs[i].ec, vecs[i].nw);
        end

        // Back-pressure mid-frame: rd must drop and nothing may be lost.
        do_reset();
        writes = 0;
        push(8'h01); push(8'h07); push(8'h0B); push(8'h0F); push(8'h02);
        step(); step();
        bus.full = 1'b1;
        for (int k = 0; k < 6; k++) step();
        bus.full = 1'b0;
        drain();
        check_status("full_hold", 3, 1, 0, 5);

        // Reset mid-frame, then the stale end marker is an orphan.
        do_reset();
        writes = 0;
        push(8'h01); push(8'h03); push(8'h07); push(8'h0B);
        drain();
        do_reset();
        push(8'h02);
        drain();
        check_status("reset_midframe", 0, 0, 1, 4);

        // Random traffic with back-pressure, gaps and occasional resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            int r;
            logic [7:0] s;
            if ($urandom_range(0, 9) < 7) begin
                r = $urandom_range(0, 99);
                if (r < 10)      s = 8'h00;
                else if (r < 20) s = 8'h01;
                else if (r < 30) s = 8'h02;
                else if (r < 42) s = {6'($urandom_range(1, 63)), 2'($urandom_range(0, 2))};
                else             s = {6'($urandom), 2'b11};
                push(s);
            end
            bus.full = ($urandom_range(0, 9) < 2);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        bus.full = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/board_level_data_physical_decoder.md
Name: board_level_data_physical_decoder

Overview:
- Receive-side counterpart of the board-level 6b/8b physical encoder.
- Pops 8-bit line symbols from the receive FIFO and classifies them as filler 0x00, frame_start 0x01, frame_end 0x02, data xxxxxx11 or illegal.
- Tracks frame state, enforces a maximum frame length and reports protocol errors.
- Writes decoded 6-bit data plus frame markers into the output FIFO that feeds the link-layer consumer.

Parameters:
MAX_FRAME_LEN, 1024, maximum data symbols per frame; must be >=1.
LEN_WIDTH, 11, width of the length counter; must hold MAX_FRAME_LEN.
CNT_WIDTH, 16, width of frame_count and error_count.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
empty  input  1  input FIFO empty
rd  output  1  input FIFO read request
valid  input  1  encoded_data is a valid popped symbol this cycle
encoded_data  input  8  line symbol from input FIFO
full  input  1  output FIFO full (programmable-full, >=2 entries slack)
wr  output  1  output FIFO write strobe
out_data  output  6  decoded payload (0 when not a data symbol)
out_start  output  1  written word is a frame start
out_end  output  1  written word is a frame end
out_abort  output  1  qualifies out_start/out_end: previous frame truncated
frame_len  output  LEN_WIDTH  data count of the last frame closed by a good frame_end
frame_count  output  CNT_WIDTH  good frames completed; wraps
error_count  output  CNT_WIDTH  protocol errors; saturates at all-ones
err_pulse  output  1  one-cycle pulse on any protocol error

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous and active-high (rst).
- Reset: all outputs 0, state IDLE, internal length counter 0. Reset mid-frame discards the frame silently; no out_abort is emitted.
- FIFO read: rd = ~full & ~empty & ~rst (combinational). A symbol is consumed only when valid=1; valid is never assumed from rd.
- Write latency: all write outputs are registered. A consumed symbol produces its wr/out_* one cycle later. wr is asserted only for emitted words; otherwise out_* hold 0.
- Slack: one symbol may be in flight when full rises, and it is still written. The output FIFO's programmable-full provides this slack.
- Classification, in priority order:
  - 0x00: filler, ignored.
  - 0x01: start.
  - 0x02: end.
  - [1:0]==2'b11: data, payload [7:2].
  - anything else: illegal. Dropped, err_pulse, error_count++, state unchanged.
- IDLE:
  - start: emit out_start=1, clear length, go to FRAME.
  - data: drop, err_pulse.
  - end: drop, err_pulse.
- FRAME:
  - data with length < MAX_FRAME_LEN: emit out_data, length++.
  - data with length == MAX_FRAME_LEN: emit out_end=1 out_abort=1, err_pulse, go to DISCARD; the symbol is dropped.
  - end: emit out_end=1, frame_len <= length, frame_count++, go to IDLE.
  - start: emit out_start=1 out_abort=1, err_pulse, clear length, stay in FRAME.
- DISCARD:
  - data: dropped silently; no error.
  - end: go to IDLE, no emit, no error.
  - start: emit out_start=1, clear length, go to FRAME.
- A truncated frame never updates frame_len or frame_count.
- error_count increments by exactly 1 per err_pulse and holds at all-ones.
- frame_count wraps to 0 after all-ones.
- At most one word is written per cycle; at most one error is counted per cycle.
- A frame of 0 data symbols is legal (start then end): frame_len=0, frame_count++.

Test Plan:
- Reset, then FIFO sequence 01,07,FF,02 with full=0 -> writes {start}, {data=0x01}, {data=0x3F}, {end}, each 1 cycle after its valid; frame_len=2, frame_count=1, error_count=0.
- Filler and illegal codes: 00,05,01,02 -> 0x00 ignored; 0x05 gives err_pulse and error_count=1; then start and end are written, frame_len=0.
- MAX_FRAME_LEN=4, sequence 01, five data 03, 02 -> start, four data words, then {end, abort} on the 5th data symbol; final 02 produces no write; frame_count=0, error_count=1, state IDLE.
- Sequence 01,0B,01,13,02 -> start, data 0x02, {start, abort}, data 0x04, end; frame_len=1, error_count=1.
- Orphans in IDLE: 0F,02 before any start -> no wr, error_count=2. Hold full=1 during a frame -> rd=0, no symbols lost; on release the stream resumes in order.
- Assert rst mid-frame after 3 data symbols, then send 02 -> outputs 0 after reset; 02 is counted as an orphan (error_count=1); frame_count=0.
